// File: rtl/aes_tlul_sequencer.sv
// TL-UL host that runs one AES-256 block operation on the aes peripheral.
// Also carries the TL-UL types and the AES register offsets that the sequencer uses.

package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [4:0] rsvd;
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    parameter tl_a_user_t TL_A_USER_DEFAULT = '{
        rsvd: 5'h0, instr_type: 4'h9, cmd_intg: 7'h0, data_intg: 7'h0
    };

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    parameter tl_h2d_t TL_H2D_DEFAULT = '{
        a_valid: 1'b0, a_opcode: PutFullData, a_param: 3'h0, a_size: 2'h0,
        a_source: 8'h0, a_address: 32'h0, a_mask: 4'h0, a_data: 32'h0,
        a_user: TL_A_USER_DEFAULT, d_ready: 1'b1
    };

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [13:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

package aes_reg_pkg;

    parameter logic [7:0] AES_KEY_SHARE0_0_OFFSET  = 8'h04;
    parameter logic [7:0] AES_KEY_SHARE1_0_OFFSET  = 8'h24;
    parameter logic [7:0] AES_IV_0_OFFSET          = 8'h44;
    parameter logic [7:0] AES_DATA_IN_0_OFFSET     = 8'h54;
    parameter logic [7:0] AES_DATA_OUT_0_OFFSET    = 8'h64;
    parameter logic [7:0] AES_CTRL_SHADOWED_OFFSET = 8'h74;
    parameter logic [7:0] AES_STATUS_OFFSET        = 8'h84;

endpackage

module aes_tlul_sequencer #(
    parameter logic [31:0] AesBase     = 32'h0,
    parameter int unsigned PollTimeout = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [1:0]        op_i,
    input  logic [5:0]        mode_i,
    input  logic [255:0]      key_i,
    input  logic [127:0]      iv_i,
    input  logic [127:0]      data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [127:0]      data_o,
    output tlul_pkg::tl_h2d_t tl_o,
    input  tlul_pkg::tl_d2h_t tl_i
);

    localparam int unsigned      PollW   = $clog2(PollTimeout + 1);
    localparam logic [PollW-1:0] PollMax = PollW'(PollTimeout);

    typedef enum logic [3:0] {
        StIdle, StCtrl0, StCtrl1, StKey0, StKey1, StIv, StDin, StPoll, StDout, StDone, StErr
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [PollW-1:0] poll_q, poll_d;
    logic             avalid_q, avalid_d;
    logic             pend_q, pend_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [127:0]     dout_q, dout_d;
    logic             lat_en;
    logic             d_hs;

    logic [1:0]       op_q;
    logic [5:0]       mode_q;
    logic [255:0]     key_q;
    logic [127:0]     iv_q;
    logic [127:0]     din_q;

    logic [7:0]       off;
    logic [31:0]      wdata;
    logic             is_read;
    logic             unused_tl;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            poll_q     <= '0;
            avalid_q   <= 1'b0;
            pend_q     <= 1'b0;
            err_code_q <= 2'd0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            poll_q     <= poll_d;
            avalid_q   <= avalid_d;
            pend_q     <= pend_d;
            err_code_q <= err_code_d;
            dout_q     <= dout_d;
        end
    end

    // Request operands are captured once at acceptance and need no reset.
    always_ff @(posedge clk_i) begin
        if (lat_en) begin
            op_q   <= op_i;
            mode_q <= mode_i;
            key_q  <= key_i;
            iv_q   <= iv_i;
            din_q  <= data_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        poll_d     = poll_q;
        avalid_d   = avalid_q;
        pend_d     = pend_q;
        err_code_d = err_code_q;
        dout_d     = dout_q;
        lat_en     = 1'b0;
        d_hs       = pend_q && tl_i.d_valid;

        if (avalid_q && tl_i.a_ready) begin
            avalid_d = 1'b0;
            pend_d   = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (req_i) begin
                    lat_en     = 1'b1;
                    state_d    = StCtrl0;
                    idx_d      = '0;
                    poll_d     = '0;
                    err_code_d = 2'd0;
                    avalid_d   = 1'b1;
                end
            end
            StDone, StErr: begin
                state_d = StIdle;
                idx_d   = '0;
            end
            default: begin
                // Only a response to our own outstanding request moves the sequence on.
                if (d_hs) begin
                    pend_d   = 1'b0;
                    avalid_d = 1'b1;
                    idx_d    = idx_q + 3'd1;
                    if (tl_i.d_error) begin
                        state_d    = StErr;
                        err_code_d = 2'd1;
                        avalid_d   = 1'b0;
                        idx_d      = '0;
                    end else begin
                        case (state_q)
                            StCtrl0: begin
                                state_d = StCtrl1;
                                idx_d   = '0;
                            end
                            StCtrl1: begin
                                state_d = StKey0;
                                idx_d   = '0;
                            end
                            StKey0: begin
                                if (idx_q == 3'd7) begin
                                    state_d = StKey1;
                                    idx_d   = '0;
                                end
                            end
                            StKey1: begin
                                if (idx_q == 3'd7) begin
                                    state_d = StIv;
                                    idx_d   = '0;
                                end
                            end
                            StIv: begin
                                if (idx_q == 3'd3) begin
                                    state_d = StDin;
                                    idx_d   = '0;
                                end
                            end
                            StDin: begin
                                if (idx_q == 3'd3) begin
                                    state_d = StPoll;
                                    idx_d   = '0;
                                    poll_d  = '0;
                                end
                            end
                            StPoll: begin
                                idx_d  = '0;
                                poll_d = poll_q + PollW'(1);
                                if (tl_i.d_data[3]) begin
                                    state_d = StDout;
                                end else if (tl_i.d_data[6]) begin
                                    state_d    = StErr;
                                    err_code_d = 2'd3;
                                    avalid_d   = 1'b0;
                                end else if (poll_d == PollMax) begin
                                    state_d    = StErr;
                                    err_code_d = 2'd2;
                                    avalid_d   = 1'b0;
                                end
                            end
                            StDout: begin
                                dout_d[{idx_q[1:0], 5'd0} +: 32] = tl_i.d_data;
                                if (idx_q == 3'd3) begin
                                    state_d  = StDone;
                                    idx_d    = '0;
                                    avalid_d = 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    // Request fields decode purely from registered state, so they stay stable while a_valid waits.
    always_comb begin
        off     = 8'h00;
        wdata   = 32'h0;
        is_read = 1'b0;
        case (state_q)
            StCtrl0, StCtrl1: begin
                off   = aes_reg_pkg::AES_CTRL_SHADOWED_OFFSET;
                wdata = {16'h0, 1'b0, 3'b001, 1'b0, 3'b100, mode_q, op_q};
            end
            StKey0: begin
                off   = aes_reg_pkg::AES_KEY_SHARE0_0_OFFSET + {3'b000, idx_q, 2'b00};
                wdata = key_q[{idx_q, 5'd0} +: 32];
            end
            StKey1: begin
                off   = aes_reg_pkg::AES_KEY_SHARE1_0_OFFSET + {3'b000, idx_q, 2'b00};
            end
            StIv: begin
                off   = aes_reg_pkg::AES_IV_0_OFFSET + {4'b0000, idx_q[1:0], 2'b00};
                wdata = iv_q[{idx_q[1:0], 5'd0} +: 32];
            end
            StDin: begin
                off   = aes_reg_pkg::AES_DATA_IN_0_OFFSET + {4'b0000, idx_q[1:0], 2'b00};
                wdata = din_q[{idx_q[1:0], 5'd0} +: 32];
            end
            StPoll: begin
                off     = aes_reg_pkg::AES_STATUS_OFFSET;
                is_read = 1'b1;
            end
            StDout: begin
                off     = aes_reg_pkg::AES_DATA_OUT_0_OFFSET + {4'b0000, idx_q[1:0], 2'b00};
                is_read = 1'b1;
            end
            default: ;
        endcase

        tl_o           = tlul_pkg::TL_H2D_DEFAULT;
        tl_o.a_valid   = avalid_q;
        tl_o.a_opcode  = is_read ? tlul_pkg::Get : tlul_pkg::PutFullData;
        tl_o.a_param   = 3'h0;
        tl_o.a_size    = 2'd2;
        tl_o.a_source  = 8'h0;
        tl_o.a_address = AesBase + {24'h0, off};
        tl_o.a_mask    = 4'hf;
        tl_o.a_data    = wdata;
        tl_o.a_user    = tlul_pkg::TL_A_USER_DEFAULT;
        tl_o.d_ready   = 1'b1;
    end

    assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                         tl_i.d_sink, tl_i.d_user};

    assign busy_o     = (state_q != StIdle) && (state_q != StDone) && (state_q != StErr);
    assign done_o     = (state_q == StDone);
    assign err_o      = (state_q == StErr);
    assign err_code_o = err_code_q;
    assign data_o     = dout_q;

endmodule

// File: doc/aes_tlul_sequencer.md
# aes_tlul_sequencer

Single-transaction TL-UL host that drives one AES block operation on the `aes` peripheral without CPU involvement. A local requester supplies key, IV, mode, operation and one 128-bit input block. The sequencer programs the AES register file over TL-UL, waits for the result, and returns the 128-bit output block. It sits between a hardware requester and the `aes` device port, in place of software register accesses.

## Interface
- `AesBase`, default `32'h0`: base address of the AES register window; every access uses `AesBase + aes_reg_pkg::AES_*_OFFSET`.
- `PollTimeout`, default `1024`: maximum STATUS reads before the operation aborts with a timeout.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `req_i`, in, 1: start request; sampled only in IDLE.
- `op_i`, in, 2: AES operation field, written to CTRL_SHADOWED.operation (2'b01 encrypt, 2'b10 decrypt).
- `mode_i`, in, 6: one-hot AES mode field, written to CTRL_SHADOWED.mode.
- `key_i`, in, 256: key share 0; key share 1 is written as all-zero; key_len is fixed to AES-256.
- `iv_i`, in, 128: IV, always written (ignored by AES in ECB mode).
- `data_i`, in, 128: input block.
- `busy_o`, out, 1: high from request acceptance to done/err.
- `done_o`, out, 1: one-cycle pulse; `data_o` is valid from this cycle until the next accepted request.
- `err_o`, out, 1: one-cycle pulse on abort.
- `err_code_o`, out, 2: 0 none, 1 TL d_error, 2 poll timeout, 3 AES fatal alert status.
- `data_o`, out, 128: output block.
- `tl_o`, out, tlul_pkg::tl_h2d_t: host request channel to `aes.tl_i`.
- `tl_i`, in, tlul_pkg::tl_d2h_t: device response channel from `aes.tl_o`.

## Operation
- States: IDLE, CTRL0, CTRL1, KEY0, KEY1, IV, DIN, POLL, DOUT, DONE, ERR.
- IDLE: when `req_i`=1, latch all inputs, set busy, go to CTRL0.
- CTRL0 and CTRL1: each writes CTRL_SHADOWED with the same value. Shadowed registers take the value only after two identical writes.
  - Value: operation=op, mode=mode, key_len=3'b100 (256), sideload=0, prng_reseed_rate=3'b001, manual_operation=0.
- KEY0: 8 writes to KEY_SHARE0_0..7 with `key_i[32*k +: 32]`, k=0..7.
- KEY1: 8 writes of zero to KEY_SHARE1_0..7.
- IV: 4 writes to IV_0..3 with `iv_i` words, low word first.
- DIN: 4 writes to DATA_IN_0..3 with `data_i` words, low word first. The fourth write triggers the AES core.
- POLL: read STATUS repeatedly.
  - bit3 (output_valid)=1: go to DOUT.
  - bit6 (alert_fatal)=1: go to ERR with code 3.
  - Otherwise increment the poll counter; when the counter reaches `PollTimeout`: ERR with code 2.
- DOUT: 4 reads of DATA_OUT_0..3 into `data_o` words, low first. The final read clears output_valid in AES.
- DONE: pulse `done_o`, clear busy, return to IDLE.
- Any response with `d_error`=1, in any state: go to ERR with code 1; the remaining sequence is skipped.
- ERR: pulse `err_o`, clear busy, go to IDLE. `err_code_o` holds until the next accepted request, which clears it to 0.
- Word index counter is 3 bits and resets to 0 on every state entry. Poll counter width is `$clog2(PollTimeout+1)`.
- Request fields:
  - Writes: a_opcode=PutFullData. Reads: a_opcode=Get.
  - a_size=2, a_mask=4'hf, a_source=0, a_param=0, a_user=TL_A_USER_DEFAULT.
  - d_ready is tied to 1.

## Timing
- Reset values:
  - `tl_o`: TL_H2D_DEFAULT with a_valid=0, d_ready=1.
  - busy, done, err: 0. err_code: 0. data_o: 0. State: IDLE.
  - Counters: 0.
- At most one outstanding TL transaction at a time.
- a_valid rises the cycle after the state/index is set and holds with stable fields until the cycle in which a_ready=1.
- The next request is issued only after the matching d_valid. Minimum is 2 cycles per access when a_ready=1 and d_valid follows the cycle after.
- Fixed access count: 2+8+8+4+4 = 26 writes, then ≥1 STATUS read, then 4 data reads.
- `req_i` while busy is ignored, with no queuing.
- d_valid arriving with no outstanding request is ignored.
- Reset asserted mid-operation:
  - Everything returns to reset values immediately.
  - An in-flight TL response after reset deassertion is dropped.

## Test plan
- FIPS-197 AES-256 ECB encrypt: key 000102…1f, data 00112233445566778899aabbccddeeff, mode ECB → `done_o` pulse, `data_o`=8ea2b7ca516745bfeafc49904b496089, exactly 26 PutFullData then Gets.
- Same key, decrypt of 8ea2b7ca… → `data_o`=00112233445566778899aabbccddeeff; CTRL_SHADOWED is written twice with identical data.
- Slave stub forces d_error=1 on the 5th write → `err_o` pulse, err_code=1, no further a_valid, busy low.
- Stub returns STATUS=0 forever with `PollTimeout`=8 → exactly 8 STATUS reads, then err_code=2.
- `req_i` held high throughout, plus a second pulse mid-sequence → only one sequence runs; `done_o` is followed by a new sequence starting from IDLE.
- Stub holds a_ready=0 for 5 cycles on a KEY write → a_valid, a_address and a_data stay stable; async reset mid-KEY0 → a_valid=0 and busy=0 immediately.
